// File: rtl/register_write_arbiter.sv
// Round-robin arbiter that grants one requester per cycle the shared register-bank write port.
// Back-to-back grants are issued without idle bubbles; outputs are registered.
module register_write_arbiter #(
    parameter int unsigned NREQ   = 4,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ*ADDR_W-1:0] req_addr,
    input  logic [NREQ*DATA_W-1:0] req_data,
    output logic [NREQ-1:0]        ack,
    output logic                   wr_en,
    output logic [ADDR_W-1:0]      wr_addr,
    output logic [DATA_W-1:0]      wr_data,
    output logic                   busy
);
    localparam int unsigned PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [PTR_W-1:0]  ptr_q;
    logic [PTR_W-1:0]  ptr_d;
    logic [PTR_W-1:0]  winner_q;
    logic [PTR_W-1:0]  winner_d;
    logic [NREQ-1:0]   eligible;
    logic [PTR_W-1:0]  scan_start;
    logic [PTR_W-1:0]  pick;
    logic              found;
    logic [NREQ-1:0]   ack_d;
    logic [ADDR_W-1:0] addr_d;
    logic [DATA_W-1:0] data_d;

    // The current winner still holds req on the edge that ends its write, so it is masked out.
    always_comb begin
        eligible   = req;
        scan_start = ptr_q;
        if (state_q == WRITE) begin
            eligible   = req & ~(NREQ'(1) << winner_q);
            scan_start = winner_q + PTR_W'(1);
        end
    end

    // First eligible requester scanning upward from scan_start, wrapping modulo NREQ.
    always_comb begin
        logic [PTR_W-1:0] idx;
        found = 1'b0;
        pick  = '0;
        idx   = '0;
        for (int k = 0; k < int'(NREQ); k++) begin
            idx = scan_start + PTR_W'(k);
            if (!found && eligible[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    always_comb begin
        state_d  = IDLE;
        ptr_d    = ptr_q;
        winner_d = winner_q;
        ack_d    = '0;
        addr_d   = '0;
        data_d   = '0;
        if (state_q == WRITE) begin
            ptr_d = scan_start;
        end
        if (found) begin
            state_d  = WRITE;
            winner_d = pick;
            ack_d    = NREQ'(1) << pick;
            addr_d   = req_addr[32'(pick) * ADDR_W +: ADDR_W];
            data_d   = req_data[32'(pick) * DATA_W +: DATA_W];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Pointer, winner and registered bank-side outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q    <= '0;
            winner_q <= '0;
            ack      <= '0;
            wr_en    <= 1'b0;
            busy     <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
        end else begin
            ptr_q    <= ptr_d;
            winner_q <= winner_d;
            ack      <= ack_d;
            wr_en    <= (state_d == WRITE);
            busy     <= (state_d == WRITE);
            wr_addr  <= addr_d;
            wr_data  <= data_d;
        end
    end

endmodule

// File: tb/tb_register_write_arbiter.sv
// Bench for register_write_arbiter: directed scenarios plus randomized traffic against a
// round-robin reference model and a register bank driven by the arbiter outputs.
module tb_register_write_arbiter;
    localparam int unsigned NREQ   = 4;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned ADDR_W = 3;
    localparam int unsigned NREG   = 8;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic [NREQ-1:0]        req;
    logic [NREQ*ADDR_W-1:0] req_addr;
    logic [NREQ*DATA_W-1:0] req_data;
    logic [NREQ-1:0]        ack;
    logic                   wr_en;
    logic [ADDR_W-1:0]      wr_addr;
    logic [DATA_W-1:0]      wr_data;
    logic                   busy;

    register_write_arbiter #(
        .NREQ  (NREQ),
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .req_addr(req_addr),
        .req_data(req_data),
        .ack     (ack),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    // Register bank of enable flip-flops fed by the arbiter.
    logic [DATA_W-1:0] bank [NREG];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NREG); i++) bank[i] <= '0;
        end else if (wr_en) begin
            bank[wr_addr] <= wr_data;
        end
    end

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;

    // Reference model state: is a write in flight, who won, what was captured, where the scan starts.
    bit              m_busy;
    int              m_win;
    int              m_ptr;
    int              m_addr;
    int              m_data;
    int              m_bank [NREG];
    logic [NREQ-1:0] oneshot;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_busy = 1'b0;
        m_win  = 0;
        m_ptr  = 0;
        m_addr = 0;
        m_data = 0;
        for (int i = 0; i < int'(NREG); i++) m_bank[i] = 0;
    endtask

    // Apply one rising edge to the model using the request inputs present at that edge.
    task automatic model_edge();
        logic [NREQ-1:0] elig;
        int start;
        int w;
        if (m_busy) begin
            m_bank[m_addr] = m_data;
            elig  = req & ~(NREQ'(1) << m_win);
            start = (m_win + 1) % int'(NREQ);
            m_ptr = start;
        end else begin
            elig  = req;
            start = m_ptr;
        end
        w = -1;
        for (int k = 0; k < int'(NREQ); k++) begin
            if (w < 0 && elig[(start + k) % int'(NREQ)]) w = (start + k) % int'(NREQ);
        end
        if (w >= 0) begin
            m_busy = 1'b1;
            m_win  = w;
            m_addr = int'(req_addr[w*ADDR_W +: ADDR_W]);
            m_data = int'(req_data[w*DATA_W +: DATA_W]);
        end else begin
            m_busy = 1'b0;
        end
    endtask

    task automatic set_src(input int i, input int a, input int d);
        req_addr[i*ADDR_W +: ADDR_W] = ADDR_W'(a);
        req_data[i*DATA_W +: DATA_W] = DATA_W'(d);
    endtask

    // One clock: advance model, compare outputs, then one-shot requesters drop after their ack edge.
    task automatic step();
        logic [NREQ-1:0] acked;
        acked = m_busy ? (NREQ'(1) << m_win) : '0;
        @(posedge clk);
        model_edge();
        #1;
        chk("wr_en", 32'(wr_en), 32'(m_busy));
        chk("busy", 32'(busy), 32'(m_busy));
        chk("ack", 32'(ack), m_busy ? (32'(1) << m_win) : 32'(0));
        if (m_busy) begin
            chk("wr_addr", 32'(wr_addr), 32'(m_addr));
            chk("wr_data", 32'(wr_data), 32'(m_data));
        end
        req = req & ~(acked & oneshot);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req   = '0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n    = 1'b0;
        req      = '0;
        req_addr = '0;
        req_data = '0;
        oneshot  = '1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_wr_en", 32'(wr_en), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_ack", 32'(ack), 32'(0));
        chk("rst_wr_addr", 32'(wr_addr), 32'(0));
        chk("rst_wr_data", 32'(wr_data), 32'(0));
        @(negedge clk);
        rst_n = 1'b1;

        // Single request from requester 0.
        set_src(0, 5, 8'hA5);
        req = 4'b0001;
        step();
        chk("single_ack", 32'(ack), 32'h1);
        chk("single_addr", 32'(wr_addr), 32'd5);
        chk("single_data", 32'(wr_data), 32'hA5);
        step();
        chk("single_idle", 32'(wr_en), 32'(0));
        chk("single_bank5", 32'(bank[5]), 32'hA5);

        // All four requesting out of reset.
        pulse_reset();
        for (int i = 0; i < int'(NREQ); i++) set_src(i, i + 1, 8'h10 + i);
        req = 4'b1111;
        for (int i = 0; i < int'(NREQ); i++) begin
            step();
            chk("all4_ack", 32'(ack), 32'(1) << i);
            chk("all4_busy", 32'(busy), 32'(1));
        end
        step();
        chk("all4_done", 32'(busy), 32'(0));

        // Requesters 0 and 2 hold req continuously and must alternate.
        oneshot = 4'b1010;
        req     = 4'b0101;
        for (int k = 0; k < 6; k++) begin
            step();
            chk("fair_ack", 32'(ack), (k % 2 == 0) ? 32'h1 : 32'h4);
        end
        req = '0;
        step();
        oneshot = '1;
        chk("fair_idle", 32'(busy), 32'(0));

        // Pointer now sits at 3: requester 3 wins before 0, then the pointer wraps to 1.
        set_src(3, 7, 8'h3C);
        set_src(0, 2, 8'hC3);
        req = 4'b1001;
        step();
        chk("wrap_ack3", 32'(ack), 32'h8);
        step();
        chk("wrap_ack0", 32'(ack), 32'h1);
        step();
        chk("wrap_idle", 32'(busy), 32'(0));
        chk("wrap_bank7", 32'(bank[7]), 32'h3C);
        chk("wrap_bank2", 32'(bank[2]), 32'hC3);
        set_src(1, 4, 8'h44);
        req = 4'b0011;
        step();
        chk("ptr1_ack", 32'(ack), 32'h2);

        // Reset in the middle of the write acknowledged to requester 1.
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_wr_en", 32'(wr_en), 32'(0));
        chk("midrst_ack", 32'(ack), 32'(0));
        chk("midrst_busy", 32'(busy), 32'(0));
        model_reset();
        req = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("postrst_ack", 32'(ack), 32'(0));
        end

        // Randomized traffic; addresses 6 and 7 are never written after the last reset.
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < int'(NREQ); i++) begin
                if (!req[i]) begin
                    if ($urandom_range(99) < 30) begin
                        req[i]     = 1'b1;
                        oneshot[i] = ($urandom_range(99) < 80);
                    end
                end else if ($urandom_range(99) < (oneshot[i] ? 3 : 10)) begin
                    req[i] = 1'b0;
                end
                set_src(i, int'($urandom_range(5)), int'($urandom_range(255)));
            end
            step();
        end
        req = '0;
        step();
        step();
        for (int i = 0; i < int'(NREG); i++) chk("bank", 32'(bank[i]), 32'(m_bank[i]));
        chk("bank6_untouched", 32'(bank[6]), 32'(0));
        chk("bank7_untouched", 32'(bank[7]), 32'(0));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/register_write_arbiter.md
REGISTER_WRITE_ARBITER -- requirements
Module: register_write_arbiter

Interface
REQ-001 The block SHALL have parameter NREQ, default 4, meaning number of requesters sharing the write port (power of two, 2..8).
REQ-002 The block SHALL have parameter DATA_W, default 8, meaning width of the data written into the shared bank of rising-edge D flip-flops with write enable.
REQ-003 The block SHALL have parameter ADDR_W, default 3, meaning register-select width; the bank holds 2**ADDR_W registers.
REQ-004 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 The block SHALL have port req, input, NREQ, per-requester write request, held high until acknowledged.
REQ-007 The block SHALL have port req_addr, input, NREQ*ADDR_W, per-requester register select, requester i in bits [i*ADDR_W +: ADDR_W].
REQ-008 The block SHALL have port req_data, input, NREQ*DATA_W, per-requester write data, requester i in bits [i*DATA_W +: DATA_W].
REQ-009 The block SHALL have port ack, output, NREQ, one-hot acknowledge, high for exactly one cycle per accepted write.
REQ-010 The block SHALL have port wr_en, output, 1, write enable to the register bank (the flip-flop w input of the selected register).
REQ-011 The block SHALL have port wr_addr, output, ADDR_W, register select for the bank.
REQ-012 The block SHALL have port wr_data, output, DATA_W, data to the bank (the flip-flop d input).
REQ-013 The block SHALL have port busy, output, 1, high whenever the FSM is in WRITE.

Function
REQ-014 The FSM SHALL have exactly two states, IDLE and WRITE, plus a round-robin pointer ptr of log2(NREQ) bits.
REQ-015 Arbitration SHALL pick the first eligible requester scanning ptr, ptr+1, ... modulo NREQ.
REQ-016 In IDLE, eligible SHALL equal req; with any eligible bit set at a rising edge, the FSM SHALL move to WRITE and register winner index, its addr and data.
REQ-017 In IDLE with req all zero, the FSM SHALL remain in IDLE with wr_en, ack, busy all 0.
REQ-018 In WRITE, wr_en SHALL be 1, wr_addr/wr_data SHALL be the registered winner values, ack[winner] SHALL be 1, all other ack bits 0.
REQ-019 Latency SHALL be one cycle: req sampled high at edge N gives wr_en and ack in cycle N..N+1; the bank captures data at edge N+1.
REQ-020 At each edge leaving WRITE, ptr SHALL become (winner+1) mod NREQ, wrapping from NREQ-1 to 0.
REQ-021 In WRITE, eligible SHALL equal req with the current winner's bit masked, since that requester still holds req at this edge.
REQ-022 In WRITE with any eligible bit set, the FSM SHALL stay in WRITE and load the new winner (back-to-back writes, no idle bubble).
REQ-023 In WRITE with no eligible bit, the FSM SHALL return to IDLE.
REQ-024 A requester that keeps req high after its ack SHALL be treated as a new request, eligible again from the following arbitration on.
REQ-025 A request withdrawn before being granted SHALL be dropped silently, with no ack issued.
REQ-026 req_addr/req_data SHALL be sampled only at the granting edge; later changes SHALL NOT affect the write in progress.
REQ-027 Two writes to the same address in consecutive cycles SHALL both be issued in grant order, so the last one wins.

Reset
REQ-028 rst_n low SHALL immediately, without waiting for clk, force state IDLE, ptr 0, winner 0, wr_en 0, wr_addr 0, wr_data 0, ack 0, busy 0.
REQ-029 Reset asserted during WRITE SHALL abort the write (wr_en drops asynchronously), and no ack SHALL be issued for it after release.
REQ-030 After rst_n rises, the first arbitration SHALL occur at the first rising clk edge with rst_n high.

Verification
REQ-031 The bench SHALL cover single request: req=0001, addr0=5, data0=8'hA5 -> one cycle wr_en=1, wr_addr=5, wr_data=A5, ack=0001, then IDLE, ptr=1.
REQ-032 The bench SHALL cover all four requesting from reset: req=1111 held (each dropped after its ack) -> acks 0001,0010,0100,1000 on four consecutive cycles, busy high for 4 cycles, ptr=0 at end.
REQ-033 The bench SHALL cover fairness under persistent load: req0 and req2 held high continuously -> acks alternate 0001,0100,0001,... and neither starves.
REQ-034 The bench SHALL cover wrap-around: ptr=3, req=1001 -> ack=1000 first, then ack=0001, ptr=1.
REQ-035 The bench SHALL cover reset mid-write: rst_n low during WRITE with ack=0010 -> wr_en/ack go 0 without a clk edge; after release with req=0000, the block stays IDLE.
REQ-036 The bench SHALL cover the bank check: the arbiter drives an 8-register bank of enable flip-flops -> each register reads back the data of its last acknowledged write, and registers never addressed keep their reset value.
